// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle controller: internal synchronous RAM
// with a programmable wait-state countdown and a one-cycle memReady acknowledge.
module mem_responder #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4096,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData,
  output logic              memReady,
  output logic              busy,
  output logic              error
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WAIT_L  = 4'(WAIT);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic              rej_q, rej_d;
  logic [DATA_W-1:0] rdata_q;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic [IDX_W-1:0]  addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              sample;
  logic              mem_we;
  logic              mem_re;

  logic [DATA_W-1:0] mem [DEPTH];

  assign sample = (state_q == IDLE) && (memRead || memWrite);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    rej_d   = rej_q;
    ready_d = 1'b0;
    error_d = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample) begin
          wr_d    = memWrite;
          // Conflicting strobes or an unimplemented word still run the full
          // countdown so the controller always receives its acknowledge.
          rej_d   = (memRead && memWrite) || ({1'b0, address} >= DEPTH_L);
          cnt_d   = WAIT_L;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ready_d = 1'b1;
          error_d = rej_q;
          mem_we  = !rej_q && wr_q;
          mem_re  = !rej_q && !wr_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!memRead && !memWrite) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      rej_q   <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rej_q   <= rej_d;
      ready_q <= ready_d;
      error_q <= error_d;
      if (mem_re) rdata_q <= mem[addr_q];
    end
  end

  // Request payload and RAM array carry no reset; the write enable is gated
  // by the reset state register, so an abandoned write never commits.
  always_ff @(posedge clk) begin
    if (sample) begin
      addr_q  <= address[IDX_W-1:0];
      wdata_q <= writeData;
    end
    if (mem_we) mem[addr_q] <= wdata_q;
  end

  assign readData = rdata_q;
  assign memReady = ready_q;
  assign error    = error_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with WAIT=2/DEPTH=256 and
// one with WAIT=0/DEPTH=4096, sharing clock and reset.
module tb_mem_responder;
  localparam int AW = 12;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          rd_a = 1'b0, wr_a = 1'b0, rd_b = 1'b0, wr_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] wd_a = '0, wd_b = '0;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          rdy_a, rdy_b, busy_a, busy_b, err_a, err_b;

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(256), .WAIT(2)) u_dut_a (
    .clk(clk), .rst(rst), .memRead(rd_a), .memWrite(wr_a), .address(addr_a),
    .writeData(wd_a), .readData(rdata_a), .memReady(rdy_a), .busy(busy_a), .error(err_a)
  );

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4096), .WAIT(0)) u_dut_b (
    .clk(clk), .rst(rst), .memRead(rd_b), .memWrite(wr_b), .address(addr_b),
    .writeData(wd_b), .readData(rdata_b), .memReady(rdy_b), .busy(busy_b), .error(err_b)
  );

  logic          sel = 1'b0;
  logic [DW-1:0] o_rdata;
  logic          o_rdy, o_busy, o_err;
  assign o_rdata = sel ? rdata_b : rdata_a;
  assign o_rdy   = sel ? rdy_b   : rdy_a;
  assign o_busy  = sel ? busy_b  : busy_a;
  assign o_err   = sel ? err_b   : err_a;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
    logic [7:0] lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!s) begin
      rd_a = r; wr_a = w; addr_a = a; wd_a = d;
    end else begin
      rd_b = r; wr_b = w; addr_b = a; wd_b = d;
    end
  endtask

  // Latency counted in negedges from the drive point: WAIT+2 (sample edge plus
  // WAIT+1 edges to the acknowledge).
  task automatic access(input logic s, input logic r, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] exp_rd, input logic exp_err,
                        input int hold, input string tag);
    exp_t e;
    int   cyc;
    logic got;
    sel = s;
    @(negedge clk);
    drive(s, r, w, a, d);
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.lat   = s ? 8'd2 : 8'd4;
    sb_q.push_back(e);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk({tag, "_busy_rise"}, o_busy, 1);
      if (o_rdy) got = 1'b1;
    end
    if (!got) begin
      chk({tag, "_timeout"}, 0, 1);
      sb_q.delete();
      drive(s, 1'b0, 1'b0, a, d);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_lat"},   cyc,     e.lat);
    chk({tag, "_rdata"}, o_rdata, e.rdata);
    chk({tag, "_err"},   o_err,   e.err);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_rdy"},  o_rdy,  0);
      chk({tag, "_hold_busy"}, o_busy, 1);
    end
    drive(s, 1'b0, 1'b0, a, d);
    @(negedge clk);
    chk({tag, "_rdy_low"},  o_rdy,  0);
    chk({tag, "_err_low"},  o_err,  0);
    chk({tag, "_busy_low"}, o_busy, 0);
  endtask

  initial begin
    #2;
    chk("rst_rdata_a", rdata_a, 0);
    chk("rst_rdy_a",   rdy_a,   0);
    chk("rst_busy_a",  busy_a,  0);
    chk("rst_err_a",   err_a,   0);
    chk("rst_rdata_b", rdata_b, 0);
    chk("rst_busy_b",  busy_b,  0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // WAIT=2 write then read
    access(0, 0, 1, 12'h010, 8'hA5, 8'h00, 0, 0, "a_wr010");
    access(0, 1, 0, 12'h010, 8'h00, 8'hA5, 0, 0, "a_rd010");

    // WAIT=0 preload and back-to-back reads
    access(1, 0, 1, 12'h000, 8'h3C, 8'h00, 0, 0, "b_wr000");
    access(1, 0, 1, 12'h001, 8'h7F, 8'h00, 0, 0, "b_wr001");
    access(1, 1, 0, 12'h000, 8'h00, 8'h3C, 0, 0, "b_rd000");
    access(1, 1, 0, 12'h001, 8'h00, 8'h7F, 0, 0, "b_rd001");

    // Strobe held 10 cycles past the ack
    access(0, 1, 0, 12'h010, 8'h00, 8'hA5, 0, 10, "a_hold");

    // Both strobes: rejected, memory and readData untouched
    access(0, 0, 1, 12'h020, 8'h11, 8'hA5, 0, 0, "a_wr020");
    access(0, 1, 1, 12'h020, 8'h99, 8'hA5, 1, 0, "a_both");
    access(0, 1, 0, 12'h020, 8'h00, 8'h11, 0, 0, "a_rd020");

    // Address beyond DEPTH=256
    access(0, 1, 0, 12'h100, 8'h00, 8'h11, 1, 0, "a_oob");

    // Reset in BUSY before the commit edge of a write
    access(0, 0, 1, 12'h030, 8'h22, 8'h11, 0, 0, "a_wr030");
    sel = 1'b0;
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 12'h030, 8'h55);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_rdata", rdata_a, 0);
    chk("mid_rst_rdy",   rdy_a,   0);
    chk("mid_rst_busy",  busy_a,  0);
    chk("mid_rst_err",   err_a,   0);
    drive(0, 1'b0, 1'b0, 12'h030, 8'h55);
    @(negedge clk);
    rst = 1'b1;
    access(0, 1, 0, 12'h030, 8'h00, 8'h22, 0, 0, "a_rd030");
    access(0, 1, 0, 12'h010, 8'h00, 8'hA5, 0, 0, "a_rd010_kept");
    access(1, 1, 0, 12'h001, 8'h00, 8'h7F, 0, 0, "b_rd001_kept");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the accumulator CPU's multicycle controller. It services the controller's `memRead`/`memWrite` strobes against an internal synchronous RAM, inserts a programmable number of wait states, and returns a one-cycle `memReady` acknowledge. The controller holds its strobe until it sees that acknowledge. It replaces the zero-latency memory model, so controller fetch, LDA, STA, ADA and ANA paths can run against realistic memory latency.

## Interface
Parameters:
- `ADDR_W`, default 12: address width; the 12-bit operand field of the instruction.
- `DATA_W`, default 8: data width; one instruction byte per access.
- `DEPTH`, default 4096: number of implemented words. Must be ≤ 2^ADDR_W.
- `WAIT`, default 2: wait states inserted before each access. Range 0..15.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `memRead`  input  1  read request, level; held by the controller until `memReady`.
- `memWrite`  input  1  write request, level; held until `memReady`.
- `address`  input  ADDR_W  word address; sampled with the request.
- `writeData`  input  DATA_W  write data; sampled with the request.
- `readData`  output  DATA_W  last successfully read word; registered; held between reads.
- `memReady`  output  1  one-cycle acknowledge that the request has completed.
- `busy`  output  1  high in BUSY and HOLD states.
- `error`  output  1  one-cycle pulse, coincident with `memReady`, when a request was rejected.

## Operation
- States:
  - IDLE: waiting for a request.
  - BUSY: wait-state countdown, then the access.
  - HOLD: waiting for the requester to release the strobe.
- IDLE:
  - A request is `memRead` or `memWrite` high at a rising edge.
  - On that edge, latch `address` and `writeData`, latch the request type, load `cnt` with WAIT, and go to BUSY.
- BUSY:
  - If `cnt` ≠ 0, decrement `cnt`.
  - If `cnt` = 0, perform the access on this edge, pulse `memReady`, and go to HOLD.
  - Read: `readData` ← mem[latched address].
  - Write: mem[latched address] ← latched data; `readData` is unchanged.
- HOLD:
  - Stay until both `memRead` and `memWrite` are low at an edge, then go to IDLE.
  - This guarantees exactly one access per controller strobe.
- Rejection: if both strobes are high at the sampling edge, or the latched address ≥ DEPTH:
  - BUSY timing is unchanged.
  - The array is not accessed and `readData` is unchanged.
  - `memReady` and `error` pulse together, so the controller never hangs.
- Request withdrawn during BUSY: the latched access still completes and `memReady` still pulses. The write commits.
- A strobe change during BUSY or HOLD is ignored. Only IDLE samples.
- The RAM array has no reset. Its contents after power-up are undefined.

## Timing
- Reset (`rst` low, asynchronous): state IDLE, `cnt` 0, `readData` 0, `memReady` 0, `busy` 0, `error` 0. Memory contents are preserved.
- Reset mid-access: the access is abandoned. An in-flight write does not commit unless its commit edge precedes the reset assertion.
- Latency: request sampled at edge E0; `memReady` is high during the cycle after edge E0+WAIT+1.
  - WAIT=0: ack one cycle after the sample cycle.
  - WAIT=2: the third edge after E0 raises `memReady`.
- `memReady` and `error` are high for exactly one cycle.
- `readData` is valid in the same cycle `memReady` is high and stays stable until the next successful read.
- `busy` goes high the cycle after E0 and low the cycle after HOLD exits.
- Minimum spacing between requests:
  - Strobe released in the `memReady` cycle: WAIT+3 cycles from sample to next sample.
  - Strobe held: the responder stays in HOLD, with no second access.

## Test plan
- Write then read, WAIT=2: write 0xA5 to address 0x010, then read 0x010. Both acks arrive 3 edges after sampling; `readData` = 0xA5 in the ack cycle; `error` stays 0.
- WAIT=0 back-to-back reads from 0x000 and 0x001, preloaded with 0x3C and 0x7F. `memReady` follows 1 edge after each sample; `readData` shows 0x3C then 0x7F; each read gets exactly one ack.
- Strobe held for 10 cycles after the ack: exactly one `memReady` pulse; `busy` stays high until the strobe drops; no second access occurs.
- `memRead`=`memWrite`=1, address 0x020: `memReady` and `error` pulse together after WAIT+1 edges; mem[0x020] and `readData` are unchanged.
- DEPTH=256, read address 0x100: `error` pulses with `memReady`; `readData` keeps its prior value.
- `rst` asserted in BUSY during a write of 0x55 to 0x030, before the commit edge: outputs go to 0 immediately; mem[0x030] keeps its old value; the next request completes normally.
